pokey_clk_enables: RTL and testbench
====================================

// Module: pokey_clk_enables
// PURPOSE
//  Produces the single-cycle clock enables every POKEY cell consumes from the 50 MHz system clock.
//  - Derives a ~1.79 MHz PHI2 timebase with a fractional phase accumulator.
//  - Emits enp (PHI2 rising) and enn (PHI2 falling) pulses, plus 64 kHz / 15 kHz base-clock enables.
//  - Replaces the testbench-only edge detectors; sits at top level and fans out to all cellN blocks and audio channels.
// PARAMETERS
//  ACC_W    24       phase accumulator width, bits
//  PH_INC   1201096  accumulator increment per clk: round(2*1.7897725e6/50e6 * 2^ACC_W)
//  DIV64    28       enp pulses per en64 pulse
//  DIV15    114      enp pulses per en15 pulse
// PORTS
//  clk      in   1  50 MHz system clock
//  R        in   1  reset, asynchronous, active-high
//  init     in   1  SKCTL init: holds base dividers cleared, suppresses en64/en15
//  sel15    in   1  AUDCTL bit0: 1 = en_base follows en15, 0 = en_base follows en64
//  enp      out  1  one-clk pulse, PHI2 rising edge
//  enn      out  1  one-clk pulse, PHI2 falling edge
//  phi2     out  1  registered PHI2 square wave
//  en64     out  1  one-clk pulse, coincident with enp, every DIV64th enp
//  en15     out  1  one-clk pulse, coincident with enp, every DIV15th enp
//  en_base  out  1  en15 when sel15=1, else en64; registered, same cycle as source
// BEHAVIOUR
//  - Clock domain and reset:
//    - Single clock domain (clk).
//    - R asserted: acc=0, phi2=0, div64=0, div15=0; all outputs 0 immediately (async).
//    - After R drops, first carry occurs after ceil(2^ACC_W/PH_INC) clk.
//  - Accumulator:
//    - Every clk: {carry,acc} <= acc + PH_INC, ACC_W+1-bit add, wraps modulo 2^ACC_W.
//    - carry=1 toggles phi2 on the same edge.
//  - PHI2 enables:
//    - enp=1 for exactly the one clk cycle after phi2 goes 0->1; enn likewise for 1->0.
//    - Carries are 13 or 14 clk apart, so enp-to-enn spacing is 13 or 14 clk and the enp period is 27 or 28 clk (mean 27.93).
//    - enp and enn are never both 1 in the same cycle; no pulse ever lasts 2 cycles.
//  - Base dividers: advance only on enp cycles.
//    - div64 counts 0..DIV64-1; en64=1 on the enp cycle where div64==DIV64-1, then div64 wraps to 0. Same rule for div15 / DIV15.
//    - init=1: both dividers forced to 0; en64/en15/en_base held 0; enp/enn/phi2 unaffected.
//    - On init falling, the first en64 occurs on the DIV64th subsequent enp.
//  - en_base select:
//    - en_base is the registered en64 or en15 per sel15, aligned with enp.
//    - sel15 changing mid-count never resets either divider and never produces a 2-cycle pulse.
//  - Reset mid-operation: any pulse in flight is cut; counting restarts from 0.
// CONFIGURATION
//  EXT_CLK_EN defined:
//    - Adds input ext_clk (1 bit, free-running ~1.79 MHz, asynchronous to clk); the accumulator is removed.
//    - ext_clk passes through a 2-flop synchronizer; phi2 = second flop.
//    - enp/enn come from a registered compare against the previous phi2.
//    - Latency: enp high in the cycle after the 3rd clk edge at which ext_clk is seen high (same for enn on low).
//    - Dividers and en_base behave as above.
//  EXT_CLK_EN undefined:
//    - No ext_clk port; internal accumulator as described.
// TESTING
//  1. R=1 for 5 clk, then release -> all outputs 0 during R; first enp within 28 clk of release.
//  2. Free run 1,000,000 clk -> enp count 35795+/-1 and enn count 35795+/-1; enp/enn overlap count 0; every enp->enn gap is 13 or 14 clk.
//  3. Free run, init=0 -> exactly one en64 per 28 enp and one en15 per 114 enp; each coincides with an enp; sel15=0/1 routes to en_base.
//  4. init=1 for 500 enp, then 0 -> no en64/en15 while high; first en64 on the 28th enp after release; enp/enn uninterrupted.
//  5. R pulsed 1 clk mid-count (div64=17) -> outputs drop asynchronously; next en64 on the 28th enp after release.
//  6. EXT_CLK_EN, ext_clk period 558.72 ns -> enp 3 clk after each ext_clk rise, enn 3 clk after each fall; one pulse per edge over 2000 edges.

Source files
------------

// File: rtl/pokey_clk_enables_if.sv
// Clock-enable bundle shared by the POKEY enable generator and every consumer cell.
// master = pokey_clk_enables; slave = the SKCTL/AUDCTL side that owns init/sel15.
interface pokey_clk_enables_if;
  logic init;
  logic sel15;
  logic enp;
  logic enn;
  logic phi2;
  logic en64;
  logic en15;
  logic en_base;

  modport master (
    input  init, sel15,
    output enp, enn, phi2, en64, en15, en_base
  );

  modport slave (
    output init, sel15,
    input  enp, enn, phi2, en64, en15, en_base
  );
endinterface

// File: rtl/pokey_clk_enables.sv
// PHI2 timebase plus 64 kHz / 15 kHz base-clock enables for all POKEY cells.
// Optional macro EXT_CLK_EN swaps the phase accumulator for a synchronized external PHI2.
module pokey_clk_enables #(
  parameter int          ACC_W  = 24,
  parameter int unsigned PH_INC = 1201096,
  parameter int          DIV64  = 28,
  parameter int          DIV15  = 114
) (
  input  logic                    clk,
  input  logic                    R,
`ifdef EXT_CLK_EN
  input  logic                    ext_clk,
`endif
  pokey_clk_enables_if.master     bus
);

  localparam int D64_W = $clog2(DIV64);
  localparam int D15_W = $clog2(DIV15);

  logic phi2_q;
  logic rise;
  logic fall;

`ifdef EXT_CLK_EN
  logic sync_q1;
  logic phi2_d;

  // ext_clk is asynchronous to clk: two flops before anything looks at it.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      sync_q1 <= 1'b0;
      phi2_q  <= 1'b0;
      phi2_d  <= 1'b0;
    end else begin
      sync_q1 <= ext_clk;
      phi2_q  <= sync_q1;
      phi2_d  <= phi2_q;
    end
  end

  assign rise = phi2_q & ~phi2_d;
  assign fall = ~phi2_q & phi2_d;
`else
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;
  logic             carry;

  assign sum   = {1'b0, acc} + (ACC_W+1)'(PH_INC);
  assign carry = sum[ACC_W];
  assign rise  = carry & ~phi2_q;
  assign fall  = carry & phi2_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would chain acc->phi2 within one edge.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      acc    <= '0;
      phi2_q <= 1'b0;
    end else begin
      acc    <= sum[ACC_W-1:0];
      phi2_q <= phi2_q ^ carry;
    end
  end
`endif

  logic             enp_q;
  logic             enn_q;
  logic             en64_q;
  logic             en15_q;
  logic             en_base_q;
  logic [D64_W-1:0] div64;
  logic [D15_W-1:0] div15;
  logic             last64;
  logic             last15;

  assign last64 = (div64 == D64_W'(DIV64 - 1));
  assign last15 = (div15 == D15_W'(DIV15 - 1));

  // Base enables are registered alongside enp so they land in the enp cycle.
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      enp_q     <= 1'b0;
      enn_q     <= 1'b0;
      en64_q    <= 1'b0;
      en15_q    <= 1'b0;
      en_base_q <= 1'b0;
      div64     <= '0;
      div15     <= '0;
    end else begin
      enp_q <= rise;
      enn_q <= fall;
      if (bus.init) begin
        en64_q    <= 1'b0;
        en15_q    <= 1'b0;
        en_base_q <= 1'b0;
        div64     <= '0;
        div15     <= '0;
      end else begin
        en64_q    <= rise & last64;
        en15_q    <= rise & last15;
        en_base_q <= rise & (bus.sel15 ? last15 : last64);
        if (rise) begin
          div64 <= last64 ? '0 : div64 + D64_W'(1);
          div15 <= last15 ? '0 : div15 + D15_W'(1);
        end
      end
    end
  end

  assign bus.phi2    = phi2_q;
  assign bus.enp     = enp_q;
  assign bus.enn     = enn_q;
  assign bus.en64    = en64_q;
  assign bus.en15    = en15_q;
  assign bus.en_base = en_base_q;

endmodule

// File: tb/tb_pokey_clk_enables.sv
// Self-checking bench for pokey_clk_enables (default build, internal accumulator).
module tb_pokey_clk_enables;

  localparam longint PH_INC = 1201096;
  localparam int     ACC_W  = 24;
  localparam int     DIV64  = 28;
  localparam int     DIV15  = 114;

  logic clk = 1'b0;
  logic R;

  pokey_clk_enables_if bus();

  pokey_clk_enables dut (
    .clk (clk),
    .R   (R),
    .bus (bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: PHI2 edge count n(t) = floor(t*PH_INC / 2^ACC_W) after t clocks.
  longint m_t;
  longint m_cnt64, m_cnt15;
  bit exp_phi2, exp_enp, exp_enn, exp_en64, exp_en15, exp_base;

  // Pulse bookkeeping from sampled DUT outputs
  longint cyc;
  longint last_enp_cyc;
  bit     prev_enp, prev_enn;
  int     n_enp, n_enn, n_64, n_15, n_base;

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_cnt64 = 0; m_cnt15 = 0;
    exp_phi2 = 0; exp_enp = 0; exp_enn = 0;
    exp_en64 = 0; exp_en15 = 0; exp_base = 0;
    last_enp_cyc = -1;
  endtask

  task automatic model_update();
    longint c_now, c_prev;
    if (R) begin
      model_reset();
      return;
    end
    m_t++;
    c_now  = (m_t * PH_INC) >> ACC_W;
    c_prev = ((m_t - 1) * PH_INC) >> ACC_W;
    exp_phi2 = c_now[0];
    exp_enp  = (c_now != c_prev) && c_now[0];
    exp_enn  = (c_now != c_prev) && !c_now[0];
    exp_en64 = 0;
    exp_en15 = 0;
    if (bus.init) begin
      m_cnt64 = 0;
      m_cnt15 = 0;
    end else if (exp_enp) begin
      m_cnt64++;
      m_cnt15++;
      exp_en64 = (m_cnt64 % DIV64) == 0;
      exp_en15 = (m_cnt15 % DIV15) == 0;
    end
    exp_base = bus.sel15 ? exp_en15 : exp_en64;
  endtask

  task automatic clear_counts();
    n_enp = 0; n_enn = 0; n_64 = 0; n_15 = 0; n_base = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_phi2"}, bus.phi2, 0);
    check({tag, "_enp"},  bus.enp,  0);
    check({tag, "_enn"},  bus.enn,  0);
    check({tag, "_en64"}, bus.en64, 0);
    check({tag, "_en15"}, bus.en15, 0);
    check({tag, "_base"}, bus.en_base, 0);
  endtask

  // One clock: model advances on the rising edge, DUT sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
    check("phi2",    bus.phi2,    exp_phi2);
    check("enp",     bus.enp,     exp_enp);
    check("enn",     bus.enn,     exp_enn);
    check("en64",    bus.en64,    exp_en64);
    check("en15",    bus.en15,    exp_en15);
    check("en_base", bus.en_base, exp_base);
    if (bus.enp && bus.enn) check("enp_enn_overlap", 1, 0);
    if (bus.enp && prev_enp) check("enp_width", 2, 1);
    if (bus.enn && prev_enn) check("enn_width", 2, 1);
    if (bus.enn && last_enp_cyc >= 0) begin
      longint gap;
      gap = cyc - last_enp_cyc;
      check("enp_enn_gap", (gap == 13 || gap == 14) ? 13 + (gap - 13) : gap, gap < 14 ? 13 : 14);
    end
    if (bus.enp) last_enp_cyc = cyc;
    prev_enp = bus.enp;
    prev_enn = bus.enn;
    n_enp  += int'(bus.enp);
    n_enn  += int'(bus.enn);
    n_64   += int'(bus.en64);
    n_15   += int'(bus.en15);
    n_base += int'(bus.en_base);
  endtask

  task automatic run_enps(input int n, input string tag);
    int budget;
    budget = n * 28 + 64;
    clear_counts();
    for (int i = 0; i < budget && n_enp < n; i++) step();
    check({tag, "_enp_seen"}, n_enp, n);
  endtask

  // Steps until en64 fires; returns how many enp pulses were seen up to and including it.
  task automatic enps_to_en64(output int idx);
    bit hit;
    hit = 0;
    clear_counts();
    for (int i = 0; i < 40 * 28 && !hit; i++) begin
      step();
      hit = bus.en64;
    end
    idx = n_enp;
  endtask

  typedef struct {
    bit    init;
    bit    sel15;
    int    n_enp;
    int    exp_64;
    int    exp_15;
    int    exp_base;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int idx;
    int first_enp;

    vecs[0] = '{init: 0, sel15: 0, n_enp: 28,  exp_64: 1, exp_15: 0, exp_base: 1};
    vecs[1] = '{init: 0, sel15: 1, n_enp: 114, exp_64: 4, exp_15: 1, exp_base: 1};
    vecs[2] = '{init: 1, sel15: 0, n_enp: 60,  exp_64: 0, exp_15: 0, exp_base: 0};
    vecs[3] = '{init: 0, sel15: 0, n_enp: 56,  exp_64: 2, exp_15: 0, exp_base: 2};
    vecs[4] = '{init: 0, sel15: 1, n_enp: 27,  exp_64: 0, exp_15: 0, exp_base: 0};
    vecs[5] = '{init: 0, sel15: 1, n_enp: 228, exp_64: 8, exp_15: 2, exp_base: 2};

    cyc = 0; prev_enp = 0; prev_enn = 0;
    model_reset();
    clear_counts();
    bus.init  = 1'b0;
    bus.sel15 = 1'b0;

    // Reset held 5 clocks, outputs zero throughout
    R = 1'b1;
    #1;
    check_outputs_zero("rst_async");
    @(negedge clk);
    for (int i = 0; i < 5; i++) step();
    check_outputs_zero("rst_hold");
    R = 1'b0;

    first_enp = 0;
    for (int i = 1; i <= 40 && first_enp == 0; i++) begin
      step();
      if (bus.enp) first_enp = i;
    end
    check("first_enp_clk", first_enp, ((longint'(1) << ACC_W) + PH_INC - 1) / PH_INC);
    check("first_enp_within_28", first_enp >= 1 && first_enp <= 28, 1);

    // Free run from a clean reset: rate ~2*1.7897725e6/50e6/2 per clk
    R = 1'b1;
    @(negedge clk);
    step();
    R = 1'b0;
    clear_counts();
    for (int i = 0; i < 20000; i++) step();
    check("freerun_enp_rate", (n_enp >= 715 && n_enp <= 717), 1);
    check("freerun_enn_rate", (n_enn >= 715 && n_enn <= 717), 1);
    check("freerun_en64", n_64, n_enp / DIV64);
    check("freerun_en15", n_15, n_enp / DIV15);

    // Table: each row starts from cleared dividers (one init clock)
    foreach (vecs[k]) begin
      bus.init = 1'b1;
      step();
      bus.init  = vecs[k].init;
      bus.sel15 = vecs[k].sel15;
      run_enps(vecs[k].n_enp, $sformatf("vec%0d", k));
      check($sformatf("vec%0d_en64", k), n_64, vecs[k].exp_64);
      check($sformatf("vec%0d_en15", k), n_15, vecs[k].exp_15);
      check($sformatf("vec%0d_base", k), n_base, vecs[k].exp_base);
    end

    // init held for 100 enp, then released: first en64 on 28th enp
    bus.sel15 = 1'b0;
    bus.init  = 1'b1;
    run_enps(100, "init_hold");
    check("init_hold_en64", n_64, 0);
    check("init_hold_en15", n_15, 0);
    check("init_hold_base", n_base, 0);
    bus.init = 1'b0;
    enps_to_en64(idx);
    check("init_release_first_en64", idx, DIV64);

    // Reset pulsed one clock when the 64 divider sits at 17
    for (int i = 0; i < 40 * 28 && !(exp_enp && (m_cnt64 % DIV64) == 17); i++) step();
    check("midcount_reached_17", m_cnt64 % DIV64, 17);
    R = 1'b1;
    #1;
    check_outputs_zero("rst_mid_async");
    step();
    R = 1'b0;
    enps_to_en64(idx);
    check("rst_mid_first_en64", idx, DIV64);

    // Randomized init/sel15 activity against the model
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 499) == 0) bus.init  = ~bus.init;
      if ($urandom_range(0, 49)  == 0) bus.sel15 = ~bus.sel15;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
